gpio_ctrl: RTL and testbench



---
 rtl/gpio_ctrl_pkg.sv | 35 +++
 rtl/gpio_in_filter.sv | 88 ++++++++
 rtl/gpio_ctrl.sv | 149 ++++++++++++++
 tb/tb_gpio_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_ctrl_pkg.sv
// ============================================================================
// Module      : gpio_ctrl_pkg
// Description : Register offsets and helpers shared by the GPIO slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpio_ctrl_pkg;

    localparam logic [7:0] GPIO_DIR     = 8'h00;
    localparam logic [7:0] GPIO_OUT     = 8'h04;
    localparam logic [7:0] GPIO_IN      = 8'h08;
    localparam logic [7:0] GPIO_OUT_SET = 8'h0C;
    localparam logic [7:0] GPIO_OUT_CLR = 8'h10;
    localparam logic [7:0] GPIO_RISE_EN = 8'h14;
    localparam logic [7:0] GPIO_FALL_EN = 8'h18;
    localparam logic [7:0] GPIO_PEND    = 8'h1C;
    localparam logic [7:0] GPIO_DBC     = 8'h20;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) begin
            m[8*k +: 8] = {8{sel[k]}};
        end
        return m;
    endfunction

    // Offsets are word-aligned; the two byte-select bits never take part.
    function automatic logic word_hit(input logic [7:0] addr, input logic [7:0] off);
        return addr[7:2] == off[7:2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_in_filter.sv
// ============================================================================
// Module      : gpio_in_filter
// Description : Pad synchronizer, optional debounce (GPIO_DEBOUNCE_EN) and
//               edge detector for the whole GPIO vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_in_filter
    import gpio_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gpio_i,
`ifdef GPIO_DEBOUNCE_EN
    input  logic [15:0]      dbc_i,
    input  logic             dbc_restart_i,
`endif
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] prev_q;
    logic             armed_q;
    logic [WIDTH-1:0] w_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= gpio_i;
            sync2_q <= sync1_q;
            prev_q  <= w_level;
            armed_q <= 1'b1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [15:0]      cnt_q;
    logic [WIDTH-1:0] hist0_q;
    logic [WIDTH-1:0] hist1_q;
    logic [WIDTH-1:0] filt_q;
    logic             w_tick;

    assign w_tick = (cnt_q == dbc_i);

    // A bit changes only when the current sample and the two before it agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            hist0_q <= '0;
            hist1_q <= '0;
            filt_q  <= '0;
        end else begin
            if (dbc_restart_i || w_tick) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (w_tick && !dbc_restart_i) begin
                hist0_q <= sync2_q;
                hist1_q <= hist0_q;
                filt_q  <= (sync2_q & hist0_q & hist1_q)
                         | (filt_q & (sync2_q | hist0_q | hist1_q));
            end
        end
    end

    assign w_level = filt_q;
`else
    assign w_level = sync2_q;
`endif

    assign level_o = w_level;
    assign rise_o  = w_level & ~prev_q & {WIDTH{armed_q}};
    assign fall_o  = ~w_level & prev_q;

endmodule

`default_nettype wire

// File: rtl/gpio_ctrl.sv
// ============================================================================
// Module      : gpio_ctrl
// Description : GPIO peripheral for I/O hub slot 4: direction, output
//               set/clear, synchronized inputs, edge interrupts. Optional
//               input debounce enabled by GPIO_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int GPIO_NUM = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          waddr_i,
    input  logic [31:0]         data_i,
    input  logic [3:0]          sel_i,
    input  logic                we_i,
    input  logic [7:0]          raddr_i,
    input  logic                rd_i,
    output logic [31:0]         data_o,
    input  logic [GPIO_NUM-1:0] gpio_i,
    output logic [GPIO_NUM-1:0] gpio_o,
    output logic [GPIO_NUM-1:0] gpio_oe,
    output logic                irq_o
);

    logic [GPIO_NUM-1:0] dir_q, dir_d;
    logic [GPIO_NUM-1:0] out_q, out_d;
    logic [GPIO_NUM-1:0] rise_en_q, rise_en_d;
    logic [GPIO_NUM-1:0] fall_en_q, fall_en_d;
    logic [GPIO_NUM-1:0] pend_q, pend_d;
    logic                irq_q;
    logic [31:0]         data_q;

    logic [31:0]         w_lane_m;
    logic [31:0]         w_wd32;
    logic [GPIO_NUM-1:0] w_m;
    logic [GPIO_NUM-1:0] w_wd;
    logic [GPIO_NUM-1:0] w_level;
    logic [GPIO_NUM-1:0] w_rise;
    logic [GPIO_NUM-1:0] w_fall;
    logic [GPIO_NUM-1:0] w_pset;
    logic [31:0]         w_rdata;
    logic                w_unused;

    assign w_lane_m = lane_mask(sel_i);
    assign w_wd32   = data_i & w_lane_m;
    assign w_m      = w_lane_m[GPIO_NUM-1:0];
    assign w_wd     = w_wd32[GPIO_NUM-1:0];
    assign w_unused = ^{waddr_i[1:0], raddr_i[1:0], data_i, w_lane_m};

`ifdef GPIO_DEBOUNCE_EN
    logic [15:0] dbc_q, dbc_d;
    logic        w_we_dbc;

    assign w_we_dbc = we_i && word_hit(waddr_i, GPIO_DBC);
    assign dbc_d    = w_we_dbc ? ((dbc_q & ~w_lane_m[15:0]) | w_wd32[15:0]) : dbc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbc_q <= '0;
        end else begin
            dbc_q <= dbc_d;
        end
    end
`endif

    gpio_in_filter #(
        .WIDTH         (GPIO_NUM)
    ) u_in_filter (
        .clk           (clk),
        .rst_n         (rst_n),
        .gpio_i        (gpio_i),
`ifdef GPIO_DEBOUNCE_EN
        .dbc_i         (dbc_q),
        .dbc_restart_i (w_we_dbc),
`endif
        .level_o       (w_level),
        .rise_o        (w_rise),
        .fall_o        (w_fall)
    );

    assign w_pset = (w_rise & rise_en_q) | (w_fall & fall_en_q);

    always_comb begin
        dir_d     = dir_q;
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        pend_d    = pend_q;
        if (we_i) begin
            if (word_hit(waddr_i, GPIO_DIR))     dir_d     = (dir_q & ~w_m) | w_wd;
            if (word_hit(waddr_i, GPIO_OUT))     out_d     = (out_q & ~w_m) | w_wd;
            if (word_hit(waddr_i, GPIO_OUT_SET)) out_d     = out_q | w_wd;
            if (word_hit(waddr_i, GPIO_OUT_CLR)) out_d     = out_q & ~w_wd;
            if (word_hit(waddr_i, GPIO_RISE_EN)) rise_en_d = (rise_en_q & ~w_m) | w_wd;
            if (word_hit(waddr_i, GPIO_FALL_EN)) fall_en_d = (fall_en_q & ~w_m) | w_wd;
            if (word_hit(waddr_i, GPIO_PEND))    pend_d    = pend_q & ~w_wd;
        end
        // A new edge wins over a simultaneous clear of the same bit.
        pend_d = pend_d | w_pset;
    end

    always_comb begin
        w_rdata = '0;
        if (word_hit(raddr_i, GPIO_DIR))     w_rdata[GPIO_NUM-1:0] = dir_q;
        if (word_hit(raddr_i, GPIO_OUT))     w_rdata[GPIO_NUM-1:0] = out_q;
        if (word_hit(raddr_i, GPIO_IN))      w_rdata[GPIO_NUM-1:0] = w_level;
        if (word_hit(raddr_i, GPIO_RISE_EN)) w_rdata[GPIO_NUM-1:0] = rise_en_q;
        if (word_hit(raddr_i, GPIO_FALL_EN)) w_rdata[GPIO_NUM-1:0] = fall_en_q;
        if (word_hit(raddr_i, GPIO_PEND))    w_rdata[GPIO_NUM-1:0] = pend_q;
`ifdef GPIO_DEBOUNCE_EN
        if (word_hit(raddr_i, GPIO_DBC))     w_rdata[15:0]         = dbc_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            irq_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            dir_q     <= dir_d;
            out_q     <= out_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
            irq_q     <= |pend_q;
            if (rd_i) begin
                data_q <= w_rdata;
            end
        end
    end

    assign gpio_oe = dir_q;
    assign gpio_o  = out_q;
    assign irq_o   = irq_q;
    assign data_o  = data_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_ctrl.sv
// ============================================================================
// Module      : tb_gpio_ctrl
// Description : Self-checking bench for gpio_ctrl; debounce scenario runs
//               when GPIO_DEBOUNCE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpio_ctrl;

    localparam int N = 16;
`ifdef GPIO_DEBOUNCE_EN
    localparam int EXTRA = 3;
`else
    localparam int EXTRA = 0;
`endif

    logic          clk;
    logic          rst_n;
    logic [7:0]    waddr;
    logic [31:0]   wdata;
    logic [3:0]    sel;
    logic          we;
    logic [7:0]    raddr;
    logic          rd;
    logic [31:0]   data_o;
    logic [N-1:0]  gpio_in;
    logic [N-1:0]  gpio_out;
    logic [N-1:0]  gpio_oe;
    logic          irq;

    int            nchk;
    int            nerr;
    logic [31:0]   sb[$];
    logic [31:0]   got;
    logic [31:0]   exp;

    gpio_ctrl #(.GPIO_NUM(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .waddr_i (waddr),
        .data_i  (wdata),
        .sel_i   (sel),
        .we_i    (we),
        .raddr_i (raddr),
        .rd_i    (rd),
        .data_o  (data_o),
        .gpio_i  (gpio_in),
        .gpio_o  (gpio_out),
        .gpio_oe (gpio_oe),
        .irq_o   (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        waddr = a; wdata = d; sel = s; we = 1'b1;
        tick(1);
        we = 1'b0;
    endtask

    // Issues a read and records what the hub should see on data_o afterwards.
    task automatic rd_req(input logic [7:0] a, input logic [31:0] e);
        sb.push_back(e);
        raddr = a; rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i <= 8; i++) begin
            rd_req(8'(i * 4), 32'h0);
            got = data_o; exp = sb.pop_front(); nchk++;
            if (got !== exp) begin nerr++; $display("FAIL reset_read off=%0h: got %h expected %h", i * 4, got, exp); end
        end
        nchk++; if (gpio_oe !== '0) begin nerr++; $display("FAIL reset_oe: got %h expected 0", gpio_oe); end
        nchk++; if (gpio_out !== '0) begin nerr++; $display("FAIL reset_out: got %h expected 0", gpio_out); end
        nchk++; if (irq !== 1'b0) begin nerr++; $display("FAIL reset_irq: got %b expected 0", irq); end
    endtask

    task automatic test_dir;
        wr(8'h00, 32'h0000_00FF, 4'b0001);
        wr(8'h00, 32'hFFFF_FFFF, 4'b0010);
        rd_req(8'h00, 32'h0000_FFFF);
        got = data_o; exp = sb.pop_front(); nchk++;
        if (got !== exp) begin nerr++; $display("FAIL dir_lanes: got %h expected %h", got, exp); end
        nchk++; if (gpio_oe !== 16'hFFFF) begin nerr++; $display("FAIL dir_oe: got %h expected ffff", gpio_oe); end
        wr(8'h00, 32'h1234_A5C3, 4'b1111);
        rd_req(8'h01, 32'h0000_A5C3);
        got = data_o; exp = sb.pop_front(); nchk++;
        if (got !== exp) begin nerr++; $display("FAIL dir_upper_bits: got %h expected %h", got, exp); end
        wr(8'h24, 32'hFFFF_FFFF, 4'b1111);
        rd_req(8'h24, 32'h0);
        got = data_o; exp = sb.pop_front(); nchk++;
        if (got !== exp) begin nerr++; $display("FAIL unmapped: got %h expected %h", got, exp); end
    endtask

    task automatic test_out;
        wr(8'h04, 32'h0, 4'b1111);
        wr(8'h0C, 32'h0000_00F0, 4'b1111);
        wr(8'h10, 32'h0000_0030, 4'b1111);
        wr(8'h0C, 32'h0000_0F00, 4'b0001);
        rd_req(8'h04, 32'h0000_00C0);
        rd_req(8'h0C, 32'h0);
        rd_req(8'h10, 32'h0);
        rd_req(8'h08, 32'h0);
        got = data_o;
        for (int i = 0; i < 3; i++) void'(sb.pop_front());
        exp = sb.pop_front(); nchk++;
        if (got !== exp) begin nerr++; $display("FAIL in_not_out: got %h expected %h", got, exp); end
        rd_req(8'h04, 32'h0000_00C0);
        got = data_o; exp = sb.pop_front(); nchk++;
        if (got !== exp) begin nerr++; $display("FAIL out_setclr: got %h expected %h", got, exp); end
        rd_req(8'h0C, 32'h0);
        got = data_o; exp = sb.pop_front(); nchk++;
        if (got !== exp) begin nerr++; $display("FAIL set_reads0: got %h expected %h", got, exp); end
        nchk++; if (gpio_out !== 16'h00C0) begin nerr++; $display("FAIL gpio_o: got %h expected 00c0", gpio_out); end
    endtask

    task automatic test_rise;
        wr(8'h14, 32'h1, 4'b1111);
        gpio_in[0] = 1'b1;
        tick(2 + EXTRA);
        rd_req(8'h08, 32'h1);
        got = data_o; exp = sb.pop_front(); nchk++;
        if (got !== exp) begin nerr++; $display("FAIL in_latency: got %h expected %h", got, exp); end
        rd_req(8'h1C, 32'h1);
        got = data_o; exp = sb.pop_front(); nchk++;
        if (got !== exp) begin nerr++; $display("FAIL pend_rise: got %h expected %h", got, exp); end
        nchk++; if (irq !== 1'b1) begin nerr++; $display("FAIL irq_set: got %b expected 1", irq); end
        wr(8'h1C, 32'h1, 4'b1111);
        tick(1);
        nchk++; if (irq !== 1'b0) begin nerr++; $display("FAIL irq_clear: got %b expected 0", irq); end
        rd_req(8'h1C, 32'h0);
        got = data_o; exp = sb.pop_front(); nchk++;
        if (got !== exp) begin nerr++; $display("FAIL pend_w1c: got %h expected %h", got, exp); end
    endtask

    task automatic test_set_clr_collision;
        wr(8'h18, 32'h2, 4'b1111);
        gpio_in[1] = 1'b1;
        tick(8 + EXTRA);
        rd_req(8'h1C, 32'h0);
        got = data_o; exp = sb.pop_front(); nchk++;
        if (got !== exp) begin nerr++; $display("FAIL no_pend_on_rise: got %h expected %h", got, exp); end
        gpio_in[1] = 1'b0;
        tick(2 + EXTRA);
        wr(8'h1C, 32'h2, 4'b0001);
        rd_req(8'h1C, 32'h2);
        got = data_o; exp = sb.pop_front(); nchk++;
        if (got !== exp) begin nerr++; $display("FAIL set_wins: got %h expected %h", got, exp); end
        wr(8'h18, 32'h0, 4'b1111);
        rd_req(8'h1C, 32'h2);
        got = data_o; exp = sb.pop_front(); nchk++;
        if (got !== exp) begin nerr++; $display("FAIL en_clear_keeps: got %h expected %h", got, exp); end
        wr(8'h1C, 32'h2, 4'b0010);
        rd_req(8'h1C, 32'h2);
        got = data_o; exp = sb.pop_front(); nchk++;
        if (got !== exp) begin nerr++; $display("FAIL w1c_lane_masked: got %h expected %h", got, exp); end
        wr(8'h1C, 32'h2, 4'b0001);
        rd_req(8'h1C, 32'h0);
        got = data_o; exp = sb.pop_front(); nchk++;
        if (got !== exp) begin nerr++; $display("FAIL pend_clear2: got %h expected %h", got, exp); end
    endtask

    task automatic test_back_to_back;
        wr(8'h04, 32'h0000_1234, 4'b1111);
        sb.push_back(32'h0000_1234);
        waddr = 8'h04; wdata = 32'h0000_5678; sel = 4'b1111; we = 1'b1;
        raddr = 8'h04; rd = 1'b1;
        tick(1);
        we = 1'b0; rd = 1'b0;
        got = data_o; exp = sb.pop_front(); nchk++;
        if (got !== exp) begin nerr++; $display("FAIL rw_same_cycle: got %h expected %h", got, exp); end
        tick(3);
        got = data_o; nchk++;
        if (got !== 32'h0000_1234) begin nerr++; $display("FAIL data_hold: got %h expected 00001234", got); end
        rd_req(8'h04, 32'h0000_5678);
        got = data_o; exp = sb.pop_front(); nchk++;
        if (got !== exp) begin nerr++; $display("FAIL rw_after: got %h expected %h", got, exp); end
    endtask

    task automatic test_mid_reset;
        wr(8'h14, 32'h8, 4'b1111);
        gpio_in[3] = 1'b1;
        tick(6 + EXTRA);
        nchk++; if (irq !== 1'b1) begin nerr++; $display("FAIL pre_reset_irq: got %b expected 1", irq); end
        rst_n = 1'b0;
        #3;
        nchk++; if (irq !== 1'b0 || data_o !== 32'h0 || gpio_oe !== '0) begin
            nerr++; $display("FAIL async_reset: irq %b data %h oe %h expected all 0", irq, data_o, gpio_oe);
        end
        tick(2);
        rst_n = 1'b1;
        wr(8'h14, 32'h8, 4'b1111);
        tick(6 + EXTRA);
        rd_req(8'h1C, 32'h8);
        got = data_o; exp = sb.pop_front(); nchk++;
        if (got !== exp) begin nerr++; $display("FAIL post_reset_edge: got %h expected %h", got, exp); end
    endtask

`ifdef GPIO_DEBOUNCE_EN
    task automatic test_debounce;
        logic [31:0] pins;
        wr(8'h20, 32'h4, 4'b1111);
        rd_req(8'h20, 32'h4);
        got = data_o; exp = sb.pop_front(); nchk++;
        if (got !== exp) begin nerr++; $display("FAIL dbc_reg: got %h expected %h", got, exp); end
        pins = 32'(gpio_in);
        gpio_in[2] = 1'b1;
        tick(8);
        gpio_in[2] = 1'b0;
        tick(40);
        rd_req(8'h08, pins);
        got = data_o; exp = sb.pop_front(); nchk++;
        if (got !== exp) begin nerr++; $display("FAIL glitch_reject: got %h expected %h", got, exp); end
        gpio_in[2] = 1'b1;
        pins = 32'(gpio_in);
        tick(40);
        rd_req(8'h08, pins);
        got = data_o; exp = sb.pop_front(); nchk++;
        if (got !== exp) begin nerr++; $display("FAIL stable_accept: got %h expected %h", got, exp); end
    endtask
`endif

    initial begin
        nchk = 0; nerr = 0;
        rst_n = 1'b0; waddr = '0; wdata = '0; sel = '0; we = 1'b0;
        raddr = '0; rd = 1'b0; gpio_in = '0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        test_reset();
        test_dir();
        test_out();
        test_rise();
        test_set_clr_collision();
        test_back_to_back();
        test_mid_reset();
`ifdef GPIO_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

`default_nettype wire
